alu_arbiter: RTL and testbench
==============================

ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 SHALL have parameter: DW, 32, operand/result width; only DW=32 is supported.
REQ-002 SHALL have port: clk  in  1  single clock; all state changes on its rising edge.
REQ-003 SHALL have port: reset  in  1  asynchronous, active-high reset.
REQ-004 SHALL have ports: reqN_valid in 1, reqN_conf in 5, reqN_sign in 1, reqN_a in DW, reqN_b in DW (N=0,1)  requester N operation offer.
REQ-005 SHALL have port: reqN_ready  out  1  operation of requester N accepted this cycle.
REQ-006 SHALL have ports: rspN_valid out 1, rspN_result out DW, rspN_zero out 1, rspN_ready in 1  response to requester N.
REQ-007 SHALL have ports: alu_conf out 5, alu_sign out 1, alu_in1 out DW, alu_in2 out DW  drive to the shared ALU's ALUConf/Sign/In1/In2.
REQ-008 SHALL have ports: alu_result in DW, alu_zero in 1  combinational Result/Zero returned by the shared ALU.

Function
REQ-009 SHALL implement a three-state FSM: IDLE, EXEC, RESP.
REQ-010 SHALL, in IDLE with at least one reqN_valid high, grant exactly one requester, assert its reqN_ready combinationally in that cycle, register its conf/sign/a/b, and move to EXEC.
REQ-011 SHALL assert reqN_ready only in IDLE, only for the granted requester, and never for both in one cycle.
REQ-012 SHALL arbitrate round-robin: with both valid, grant the requester not granted last; with one valid, grant it regardless of history.
REQ-013 SHALL track last grant in a 1-bit register updated on each acceptance.
REQ-014 SHALL drive alu_conf/alu_sign/alu_in1/alu_in2 from the registered operation at all times (stable throughout EXEC), never directly from reqN inputs.
REQ-015 SHALL, in EXEC, capture alu_result and alu_zero into response registers and move to RESP after exactly one cycle.
REQ-016 SHALL, in RESP, assert rspN_valid for the granted requester only, with rspN_result/rspN_zero equal to the captured values; the other requester's rsp*_valid stays low.
REQ-017 SHALL hold RESP, valid and data unchanged, until the granted rspN_ready is high, then return to IDLE on that edge.
REQ-018 SHALL give minimum latency: accept at edge T, rspN_valid high in cycle T+2; minimum issue interval 3 cycles per operation.
REQ-019 SHALL pass reqN_conf unchanged to the ALU, including unsupported codes (ALU yields 0; Zero=1).
REQ-020 SHALL ignore reqN_valid while in EXEC or RESP; requesters hold their offer until reqN_ready.
REQ-021 SHALL drive rspN_result and rspN_zero to zero whenever rspN_valid is low.

Reset
REQ-022 SHALL, on reset high, immediately force state IDLE, all reqN_ready and rspN_valid low, alu_conf/alu_sign/alu_in1/alu_in2 and response registers to 0, and last grant to 1 (so requester 0 wins the first contest).
REQ-023 SHALL discard any in-flight operation on reset; no response is issued for it after reset releases.
REQ-024 SHALL accept a new request in the first cycle after reset deassertion.

Verification
REQ-025 Single op: req0 conf=00000 sign=1 a=5 b=-3, rsp0_ready=1 -> req0_ready same cycle, alu_in1=5 alu_in2=-3 in EXEC, rsp0_valid at T+2 with result=2 zero=0.
REQ-026 Contest after reset: both valid, req0 conf=00001 a=7 b=7, req1 conf=00011 a=0xF0 b=0x0F -> req0 first (result 0, zero=1), req1 next (result 0xFF), rsp1_valid never overlaps rsp0_valid.
REQ-027 Fairness: both valid continuously for 6 ops -> grant order 0,1,0,1,0,1.
REQ-028 Backpressure: rsp1_ready low 4 cycles in RESP -> rsp1_valid/result stable, req0 not accepted until cycle after rsp1_ready high.
REQ-029 Reset mid-EXEC: assert reset during EXEC of req1 sltu a=1 b=2 -> all outputs 0 immediately, no rsp1_valid after release, next contest granted to req0.
REQ-030 Shift/illegal: req0 conf=00110 a=4 b=1 -> result 16; conf=11111 -> result 0, zero=1.

Source files
------------

// File: rtl/alu_arbiter.sv
// alu_arbiter
//   Shares one combinational ALU between two requesters. An operation is
//   accepted in IDLE, held in registers for one EXEC cycle while the ALU
//   evaluates it, and the captured result is presented in RESP until the
//   owning requester takes it. Contests are resolved round-robin.
//
// Ports
//   clk, reset                      clock, async active-high reset
//   reqN_valid/conf/sign/a/b        operation offer from requester N (N=0,1)
//   reqN_ready                      offer of requester N accepted this cycle
//   rspN_valid/result/zero          response to requester N (zeroed when idle)
//   rspN_ready                      requester N takes its response
//   alu_conf/sign/in1/in2           registered operation driven to the ALU
//   alu_result, alu_zero            combinational ALU outputs
//
// state | meaning
// IDLE  | waiting for an offer; arbitration and acceptance happen here
// EXEC  | operation registers drive the ALU; result captured on exit
// RESP  | captured result offered to the granted requester
module alu_arbiter #(
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req0_valid,
  input  logic [4:0]    req0_conf,
  input  logic          req0_sign,
  input  logic [DW-1:0] req0_a,
  input  logic [DW-1:0] req0_b,
  output logic          req0_ready,
  input  logic          req1_valid,
  input  logic [4:0]    req1_conf,
  input  logic          req1_sign,
  input  logic [DW-1:0] req1_a,
  input  logic [DW-1:0] req1_b,
  output logic          req1_ready,
  output logic          rsp0_valid,
  output logic [DW-1:0] rsp0_result,
  output logic          rsp0_zero,
  input  logic          rsp0_ready,
  output logic          rsp1_valid,
  output logic [DW-1:0] rsp1_result,
  output logic          rsp1_zero,
  input  logic          rsp1_ready,
  output logic [4:0]    alu_conf,
  output logic          alu_sign,
  output logic [DW-1:0] alu_in1,
  output logic [DW-1:0] alu_in2,
  input  logic [DW-1:0] alu_result,
  input  logic          alu_zero
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t        state_q, state_d;
  logic          grant_q, grant_d;
  logic          last_q, last_d;
  logic [4:0]    conf_q, conf_d;
  logic          sign_q, sign_d;
  logic [DW-1:0] a_q, a_d;
  logic [DW-1:0] b_q, b_d;
  logic [DW-1:0] res_q, res_d;
  logic          zero_q, zero_d;
  logic          sel;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      grant_q <= 1'b0;
      last_q  <= 1'b1;
      conf_q  <= '0;
      sign_q  <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      conf_q  <= conf_d;
      sign_q  <= sign_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      zero_q  <= zero_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    last_d     = last_q;
    conf_d     = conf_q;
    sign_d     = sign_q;
    a_d        = a_q;
    b_d        = b_q;
    res_d      = res_q;
    zero_d     = zero_q;
    req0_ready = 1'b0;
    req1_ready = 1'b0;

    // Both asking: favour the one not served last. One asking: it wins.
    if (req0_valid && req1_valid) sel = ~last_q;
    else                          sel = req1_valid;

    case (state_q)
      IDLE: begin
        // Ready is combinational on the offer, so it must also be masked
        // while reset is held, not just by the cleared state.
        if (!reset && (req0_valid || req1_valid)) begin
          req0_ready = ~sel;
          req1_ready = sel;
          grant_d    = sel;
          last_d     = sel;
          conf_d     = sel ? req1_conf : req0_conf;
          sign_d     = sel ? req1_sign : req0_sign;
          a_d        = sel ? req1_a    : req0_a;
          b_d        = sel ? req1_b    : req0_b;
          state_d    = EXEC;
        end
      end
      EXEC: begin
        res_d   = alu_result;
        zero_d  = alu_zero;
        state_d = RESP;
      end
      RESP: begin
        if (grant_q ? rsp1_ready : rsp0_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign rsp0_valid  = (state_q == RESP) && !grant_q;
  assign rsp1_valid  = (state_q == RESP) && grant_q;
  assign rsp0_result = rsp0_valid ? res_q  : '0;
  assign rsp0_zero   = rsp0_valid ? zero_q : 1'b0;
  assign rsp1_result = rsp1_valid ? res_q  : '0;
  assign rsp1_zero   = rsp1_valid ? zero_q : 1'b0;

  assign alu_conf = conf_q;
  assign alu_sign = sign_q;
  assign alu_in1  = a_q;
  assign alu_in2  = b_q;

endmodule

// File: tb/tb_alu_arbiter.sv
module tb_alu_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        req0_valid, req1_valid, req0_sign, req1_sign;
  logic [4:0]  req0_conf, req1_conf;
  logic [31:0] req0_a, req0_b, req1_a, req1_b;
  logic        req0_ready, req1_ready;
  logic        rsp0_valid, rsp1_valid, rsp0_zero, rsp1_zero;
  logic [31:0] rsp0_result, rsp1_result;
  logic        rsp0_ready, rsp1_ready;
  logic [4:0]  alu_conf;
  logic        alu_sign;
  logic [31:0] alu_in1, alu_in2, alu_result;
  logic        alu_zero;

  always #5 clk = ~clk;

  alu_arbiter #(.DW(32)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_conf(req0_conf), .req0_sign(req0_sign),
    .req0_a(req0_a), .req0_b(req0_b), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_conf(req1_conf), .req1_sign(req1_sign),
    .req1_a(req1_a), .req1_b(req1_b), .req1_ready(req1_ready),
    .rsp0_valid(rsp0_valid), .rsp0_result(rsp0_result), .rsp0_zero(rsp0_zero),
    .rsp0_ready(rsp0_ready),
    .rsp1_valid(rsp1_valid), .rsp1_result(rsp1_result), .rsp1_zero(rsp1_zero),
    .rsp1_ready(rsp1_ready),
    .alu_conf(alu_conf), .alu_sign(alu_sign), .alu_in1(alu_in1), .alu_in2(alu_in2),
    .alu_result(alu_result), .alu_zero(alu_zero)
  );

  // Shared ALU: add, sub, and, or, xor, nor, sll, srl, sra, slt/sltu;
  // every other code yields 0.
  function automatic logic [31:0] alu_fn(input logic [4:0] c, input logic s,
                                         input logic [31:0] a, input logic [31:0] b);
    case (c)
      5'd0: return a + b;
      5'd1: return a - b;
      5'd2: return a & b;
      5'd3: return a | b;
      5'd4: return a ^ b;
      5'd5: return ~(a | b);
      5'd6: return b << a[4:0];
      5'd7: return b >> a[4:0];
      5'd8: return $signed(b) >>> a[4:0];
      5'd9: return s ? {31'b0, $signed(a) < $signed(b)} : {31'b0, a < b};
      default: return 32'd0;
    endcase
  endfunction

  assign alu_result = alu_fn(alu_conf, alu_sign, alu_in1, alu_in2);
  assign alu_zero   = (alu_result == 32'd0);

  int n_cmp = 0;
  int n_bad = 0;
  int grants[$];

  // Reference: who owns the ALU, how many cycles since acceptance, the
  // accepted operation and the last winner.
  int          m_owner, m_age, m_acc_last;
  logic        m_last, m_sign;
  logic [4:0]  m_conf;
  logic [31:0] m_a, m_b;

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic mreset();
    m_owner = -1; m_age = 0; m_acc_last = -1; m_last = 1'b1;
    m_conf = '0; m_sign = 1'b0; m_a = '0; m_b = '0;
  endtask

  task automatic set_req(input int n, input logic v, input logic [4:0] c, input logic s,
                         input logic [31:0] a, input logic [31:0] b);
    if (n == 0) begin
      req0_valid = v; req0_conf = c; req0_sign = s; req0_a = a; req0_b = b;
    end else begin
      req1_valid = v; req1_conf = c; req1_sign = s; req1_a = a; req1_b = b;
    end
  endtask

  // One clock: compare every output against the reference mid-cycle, then
  // advance the reference across the rising edge. Returns at edge + 1.
  task automatic cycle();
    int          acc;
    logic        ev0, ev1;
    logic [31:0] er;
    @(negedge clk);
    acc = -1;
    if (m_owner < 0) begin
      if (req0_valid && req1_valid) acc = m_last ? 0 : 1;
      else if (req0_valid)          acc = 0;
      else if (req1_valid)          acc = 1;
    end
    ev0 = (m_owner == 0) && (m_age >= 2);
    ev1 = (m_owner == 1) && (m_age >= 2);
    er  = alu_fn(m_conf, m_sign, m_a, m_b);
    chk1 ("cyc_req0_ready", req0_ready, acc == 0);
    chk1 ("cyc_req1_ready", req1_ready, acc == 1);
    chk1 ("cyc_rsp0_valid", rsp0_valid, ev0);
    chk1 ("cyc_rsp1_valid", rsp1_valid, ev1);
    chk32("cyc_rsp0_result", rsp0_result, ev0 ? er : 32'd0);
    chk32("cyc_rsp1_result", rsp1_result, ev1 ? er : 32'd0);
    chk1 ("cyc_rsp0_zero", rsp0_zero, ev0 ? (er == 32'd0) : 1'b0);
    chk1 ("cyc_rsp1_zero", rsp1_zero, ev1 ? (er == 32'd0) : 1'b0);
    chk32("cyc_alu_conf", {27'd0, alu_conf}, {27'd0, m_conf});
    chk1 ("cyc_alu_sign", alu_sign, m_sign);
    chk32("cyc_alu_in1", alu_in1, m_a);
    chk32("cyc_alu_in2", alu_in2, m_b);
    if (req0_ready) grants.push_back(0);
    if (req1_ready) grants.push_back(1);
    if (acc >= 0) begin
      m_owner = acc; m_age = 1; m_last = (acc == 1);
      m_conf = (acc == 1) ? req1_conf : req0_conf;
      m_sign = (acc == 1) ? req1_sign : req0_sign;
      m_a    = (acc == 1) ? req1_a    : req0_a;
      m_b    = (acc == 1) ? req1_b    : req0_b;
    end else if (m_owner >= 0) begin
      if (m_age < 2) m_age++;
      else if ((m_owner == 0 && rsp0_ready) || (m_owner == 1 && rsp1_ready)) m_owner = -1;
    end
    m_acc_last = acc;
    @(posedge clk);
    #1;
  endtask

  // Assert reset between edges, check everything is forced low at once,
  // then release just after a rising edge.
  task automatic do_reset();
    #1;
    reset = 1'b1;
    #1;
    chk1 ("rst_req0_ready", req0_ready, 1'b0);
    chk1 ("rst_req1_ready", req1_ready, 1'b0);
    chk1 ("rst_rsp0_valid", rsp0_valid, 1'b0);
    chk1 ("rst_rsp1_valid", rsp1_valid, 1'b0);
    chk32("rst_rsp0_result", rsp0_result, 32'd0);
    chk32("rst_rsp1_result", rsp1_result, 32'd0);
    chk32("rst_alu_conf", {27'd0, alu_conf}, 32'd0);
    chk1 ("rst_alu_sign", alu_sign, 1'b0);
    chk32("rst_alu_in1", alu_in1, 32'd0);
    chk32("rst_alu_in2", alu_in2, 32'd0);
    mreset();
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic rand_offer(input int n);
    logic [4:0]  c;
    logic [31:0] a, b;
    c = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(10, 31)) : 5'($urandom_range(0, 9));
    a = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
    b = ($urandom_range(0, 3) == 0) ? a : $urandom;
    set_req(n, 1'b1, c, 1'($urandom_range(0, 1)), a, b);
  endtask

  initial begin
    int g;
    reset = 1'b1;
    set_req(0, 1'b0, 5'd0, 1'b0, 32'd0, 32'd0);
    set_req(1, 1'b0, 5'd0, 1'b0, 32'd0, 32'd0);
    rsp0_ready = 1'b1;
    rsp1_ready = 1'b1;
    mreset();
    @(posedge clk);
    #1;
    reset = 1'b0;

    // Single add: 5 + (-3) = 2
    set_req(0, 1'b1, 5'd0, 1'b1, 32'd5, 32'hFFFF_FFFD);
    #1;
    chk1("A_req0_ready", req0_ready, 1'b1);
    chk1("A_req1_ready", req1_ready, 1'b0);
    cycle();
    set_req(0, 1'b0, 5'd0, 1'b0, 32'd0, 32'd0);
    #1;
    chk32("A_alu_in1", alu_in1, 32'd5);
    chk32("A_alu_in2", alu_in2, 32'hFFFF_FFFD);
    chk1 ("A_rsp0_early", rsp0_valid, 1'b0);
    cycle();
    #1;
    chk1 ("A_rsp0_valid", rsp0_valid, 1'b1);
    chk32("A_result", rsp0_result, 32'd2);
    chk1 ("A_zero", rsp0_zero, 1'b0);
    cycle();
    #1;
    chk1 ("A_rsp0_done", rsp0_valid, 1'b0);
    chk32("A_result_idle", rsp0_result, 32'd0);

    // Contest straight after reset
    set_req(0, 1'b1, 5'd1, 1'b0, 32'd7, 32'd7);
    set_req(1, 1'b1, 5'd3, 1'b0, 32'h0000_00F0, 32'h0000_000F);
    do_reset();
    #1;
    chk1("B_req0_ready", req0_ready, 1'b1);
    chk1("B_req1_ready", req1_ready, 1'b0);
    cycle();
    set_req(0, 1'b0, 5'd0, 1'b0, 32'd0, 32'd0);
    cycle();
    #1;
    chk1 ("B_rsp0_valid", rsp0_valid, 1'b1);
    chk32("B_rsp0_result", rsp0_result, 32'd0);
    chk1 ("B_rsp0_zero", rsp0_zero, 1'b1);
    chk1 ("B_rsp1_quiet", rsp1_valid, 1'b0);
    cycle();
    #1;
    chk1("B_req1_ready", req1_ready, 1'b1);
    cycle();
    set_req(1, 1'b0, 5'd0, 1'b0, 32'd0, 32'd0);
    cycle();
    #1;
    chk1 ("B_rsp1_valid", rsp1_valid, 1'b1);
    chk32("B_rsp1_result", rsp1_result, 32'h0000_00FF);
    chk1 ("B_rsp1_zero", rsp1_zero, 1'b0);
    chk1 ("B_rsp0_quiet", rsp0_valid, 1'b0);
    cycle();

    // Fairness under continuous contention
    grants.delete();
    set_req(0, 1'b1, 5'd0, 1'b0, 32'd10, 32'd1);
    set_req(1, 1'b1, 5'd1, 1'b0, 32'd10, 32'd1);
    repeat (18) cycle();
    chk32("C_grant_count", 32'(grants.size()), 32'd6);
    for (int i = 0; i < 6; i++) begin
      g = (i < grants.size()) ? grants[i] : -1;
      chk32($sformatf("C_grant_%0d", i), 32'(g), 32'(i % 2));
    end
    set_req(0, 1'b0, 5'd0, 1'b0, 32'd0, 32'd0);
    set_req(1, 1'b0, 5'd0, 1'b0, 32'd0, 32'd0);

    // Backpressure on requester 1 while requester 0 waits
    rsp1_ready = 1'b0;
    set_req(1, 1'b1, 5'd4, 1'b0, 32'h0000_FF00, 32'h0000_0FF0);
    #1;
    chk1("D_req1_ready", req1_ready, 1'b1);
    cycle();
    set_req(1, 1'b0, 5'd0, 1'b0, 32'd0, 32'd0);
    set_req(0, 1'b1, 5'd0, 1'b0, 32'd1, 32'd1);
    cycle();
    for (int i = 0; i < 4; i++) begin
      #1;
      chk1 ("D_rsp1_valid", rsp1_valid, 1'b1);
      chk32("D_rsp1_result", rsp1_result, 32'h0000_F0F0);
      chk1 ("D_req0_blocked", req0_ready, 1'b0);
      cycle();
    end
    rsp1_ready = 1'b1;
    #1;
    chk1("D_rsp1_hold", rsp1_valid, 1'b1);
    chk1("D_req0_still_blocked", req0_ready, 1'b0);
    cycle();
    #1;
    chk1("D_req0_ready", req0_ready, 1'b1);
    cycle();
    set_req(0, 1'b0, 5'd0, 1'b0, 32'd0, 32'd0);
    cycle();
    cycle();

    // Reset while requester 1's sltu is in EXEC
    set_req(1, 1'b1, 5'd9, 1'b0, 32'd1, 32'd2);
    cycle();
    set_req(0, 1'b1, 5'd0, 1'b0, 32'd3, 32'd4);
    #1;
    chk32("E_exec_conf", {27'd0, alu_conf}, 32'd9);
    do_reset();
    #1;
    chk1("E_req0_ready", req0_ready, 1'b1);
    chk1("E_req1_ready", req1_ready, 1'b0);
    cycle();
    set_req(0, 1'b0, 5'd0, 1'b0, 32'd0, 32'd0);
    set_req(1, 1'b0, 5'd0, 1'b0, 32'd0, 32'd0);
    for (int i = 0; i < 4; i++) begin
      #1;
      chk1("E_no_rsp1", rsp1_valid, 1'b0);
      cycle();
    end

    // Shift and unsupported code
    set_req(0, 1'b1, 5'd6, 1'b0, 32'd4, 32'd1);
    cycle();
    set_req(0, 1'b0, 5'd0, 1'b0, 32'd0, 32'd0);
    cycle();
    #1;
    chk32("F_sll_result", rsp0_result, 32'd16);
    chk1 ("F_sll_zero", rsp0_zero, 1'b0);
    cycle();
    set_req(0, 1'b1, 5'd31, 1'b0, 32'd4, 32'd1);
    cycle();
    set_req(0, 1'b0, 5'd0, 1'b0, 32'd0, 32'd0);
    cycle();
    #1;
    chk1 ("F_illegal_valid", rsp0_valid, 1'b1);
    chk32("F_illegal_result", rsp0_result, 32'd0);
    chk1 ("F_illegal_zero", rsp0_zero, 1'b1);
    cycle();

    // Random traffic with occasional resets
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 199) == 0) do_reset();
      else cycle();
      if (m_acc_last == 0) begin
        if ($urandom_range(0, 1) == 0) rand_offer(0);
        else set_req(0, 1'b0, 5'd0, 1'b0, 32'd0, 32'd0);
      end else if (!req0_valid && $urandom_range(0, 2) == 0) rand_offer(0);
      if (m_acc_last == 1) begin
        if ($urandom_range(0, 1) == 0) rand_offer(1);
        else set_req(1, 1'b0, 5'd0, 1'b0, 32'd0, 32'd0);
      end else if (!req1_valid && $urandom_range(0, 2) == 0) rand_offer(1);
      rsp0_ready = ($urandom_range(0, 3) != 0);
      rsp1_ready = ($urandom_range(0, 3) != 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
